shade_ramp_ctrl: RTL



---
 rtl/shade_pkg.sv | 17 +
 rtl/shade_channel.sv | 64 ++++++
 rtl/shade_ramp_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/shade_pkg.sv
// Shared definitions for the shade ramp controller: time-code encodings and
// the per-channel motor direction state.
package shade_pkg;

    localparam logic [3:0] TC_OFF   = 4'b0000;
    localparam logic [3:0] TC_NOON  = 4'b0001;
    localparam logic [3:0] TC_DUSK  = 4'b0010;
    localparam logic [3:0] TC_USER  = 4'b0100;
    localparam logic [3:0] TC_NIGHT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } shade_st_t;

endpackage

// File: rtl/shade_channel.sv
// One shade channel: direction FSM, position register and at-target flag.
// Position only moves on a prescaler tick, one level per tick.
module shade_channel
    import shade_pkg::*;
#(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [LW-1:0] target,
    output logic [LW-1:0] pos,
    output logic          moving,
    output logic          at_target
);

    shade_st_t     state;
    shade_st_t     state_nxt;
    logic [LW-1:0] pos_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            at_target <= 1'b1;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            at_target <= (pos == target);
        end
    end

    // A target on the far side while moving parks the motor for one tick
    // before it may start the other way (reversal dwell).
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (target > pos) begin
                        state_nxt = UP;
                        pos_nxt   = pos + 1'b1;
                    end else if (target < pos) begin
                        state_nxt = DOWN;
                        pos_nxt   = pos - 1'b1;
                    end
                end
                UP: begin
                    if (target > pos) pos_nxt = pos + 1'b1;
                    else              state_nxt = IDLE;
                end
                DOWN: begin
                    if (target < pos) pos_nxt = pos - 1'b1;
                    else              state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign moving = (state != IDLE);

endmodule

// File: rtl/shade_ramp_ctrl.sv
// Multi-window shade controller: decodes the time code into per-channel
// targets and ramps each shade channel toward its target at a paced rate.
module shade_ramp_ctrl
    import shade_pkg::*;
#(
    parameter int CH         = 2,
    parameter int LW         = 4,
    parameter int STEP_DIV   = 8,
    parameter int DUSK_LEVEL = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [3:0]                          tcode,
    input  logic [CH*LW-1:0]                    ulight,
    input  logic                                ovr_valid,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ovr_ch,
    input  logic [LW-1:0]                       ovr_level,
    output logic                                ovr_ready,
    output logic [CH*LW-1:0]                    wshade,
    output logic [CH-1:0]                       moving,
    output logic [CH-1:0]                       at_target
);

    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int LMAX = (1 << LW) - 1;
    localparam int CNTW = $clog2(STEP_DIV);

    logic [CNTW-1:0]          cnt;
    logic                     tick;
    logic [3:0]               tcode_q;
    logic                     tcode_chg;
    logic [CH-1:0]            ovr_flag;
    logic [CH-1:0][LW-1:0]    ovr_lvl;
    logic [CH-1:0][LW-1:0]    target;

    assign tick      = (cnt == CNTW'(STEP_DIV - 1));
    assign tcode_chg = (tcode != tcode_q);
    assign ovr_ready = !rst;

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // A time-code change releases every pinned channel, even one being
    // pinned in the same cycle; indices past the last channel match nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcode_q  <= TC_OFF;
            ovr_flag <= '0;
            ovr_lvl  <= '0;
        end else begin
            tcode_q <= tcode;
            if (tcode_chg) begin
                ovr_flag <= '0;
            end else if (ovr_valid && ovr_ready) begin
                for (int i = 0; i < CH; i++) begin
                    if (ovr_ch == CHW'(i)) begin
                        ovr_flag[i] <= 1'b1;
                        ovr_lvl[i]  <= ovr_level;
                    end
                end
            end
        end
    end

    always_comb begin
        target = '0;
        for (int i = 0; i < CH; i++) begin
            case (tcode)
                TC_NOON: target[i] = LW'(LMAX);
                TC_DUSK: target[i] = LW'(DUSK_LEVEL);
                TC_USER: target[i] = ovr_flag[i] ? ovr_lvl[i] : ulight[i*LW +: LW];
                default: target[i] = '0;
            endcase
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        shade_channel #(
            .LW(LW)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .target    (target[g]),
            .pos       (wshade[g*LW +: LW]),
            .moving    (moving[g]),
            .at_target (at_target[g])
        );
    end

endmodule
